// File: rtl/uriscv_muldiv_issue_if.sv
// Request/response and multiply-divide unit signal bundle for uriscv_muldiv_issue.
// The slave modport is the issue block; the master modport is its environment.
interface uriscv_muldiv_issue_if #(
    parameter int unsigned N = 16
);
    logic         req_valid_i;
    logic         req_ready_o;
    logic [2:0]   req_op_i;
    logic [N-1:0] req_ra_i;
    logic [N-1:0] req_rb_i;

    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [N-1:0] rsp_result_o;
    logic         rsp_err_o;

    logic         md_valid_o;
    logic         md_inst_mul_o;
    logic         md_inst_mulh_o;
    logic         md_inst_mulhsu_o;
    logic         md_inst_mulhu_o;
    logic         md_inst_div_o;
    logic         md_inst_divu_o;
    logic         md_inst_rem_o;
    logic         md_inst_remu_o;
    logic [N-1:0] md_operand_ra_o;
    logic [N-1:0] md_operand_rb_o;
    logic         md_stall_i;
    logic         md_ready_i;
    logic [N-1:0] md_result_i;

    modport slave (
        input  req_valid_i, req_op_i, req_ra_i, req_rb_i,
        output req_ready_o,
        output rsp_valid_o, rsp_result_o, rsp_err_o,
        input  rsp_ready_i,
        output md_valid_o, md_inst_mul_o, md_inst_mulh_o, md_inst_mulhsu_o, md_inst_mulhu_o,
        output md_inst_div_o, md_inst_divu_o, md_inst_rem_o, md_inst_remu_o,
        output md_operand_ra_o, md_operand_rb_o,
        input  md_stall_i, md_ready_i, md_result_i
    );

    modport master (
        output req_valid_i, req_op_i, req_ra_i, req_rb_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_result_o, rsp_err_o,
        output rsp_ready_i,
        input  md_valid_o, md_inst_mul_o, md_inst_mulh_o, md_inst_mulhsu_o, md_inst_mulhu_o,
        input  md_inst_div_o, md_inst_divu_o, md_inst_rem_o, md_inst_remu_o,
        input  md_operand_ra_o, md_operand_rb_o,
        output md_stall_i, md_ready_i, md_result_i
    );
endinterface

// File: rtl/uriscv_muldiv_issue.sv
// Single-outstanding issue/response sequencer in front of a RISC-V multiply/divide unit.
// Optional watchdog selected by defining URISCV_MULDIV_ISSUE_TIMEOUT_EN.
module uriscv_muldiv_issue #(
    parameter int unsigned N       = 16,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    uriscv_muldiv_issue_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t       state_q, state_d;
    logic         md_valid_q, md_valid_d;
    logic [7:0]   inst_q, inst_d;
    logic [N-1:0] ra_q, ra_d;
    logic [N-1:0] rb_q, rb_d;
    logic [N-1:0] result_q, result_d;
    logic         rsp_valid_q;
    logic         timeout_hit;

    // Next state; md_* next values are zero unless the next cycle is an ISSUE cycle
    always_comb begin
        state_d    = state_q;
        md_valid_d = 1'b0;
        inst_d     = '0;
        ra_d       = '0;
        rb_d       = '0;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    state_d    = S_ISSUE;
                    md_valid_d = 1'b1;
                    inst_d     = 8'b1 << bus.req_op_i;
                    ra_d       = bus.req_ra_i;
                    rb_d       = bus.req_rb_i;
                end
            end
            S_ISSUE: begin
                if (timeout_hit) begin
                    state_d  = S_RESP;
                    result_d = '0;
                end else if (bus.md_stall_i) begin
                    md_valid_d = 1'b1;
                    inst_d     = inst_q;
                    ra_d       = ra_q;
                    rb_d       = rb_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.md_ready_i) begin
                    state_d  = S_RESP;
                    result_d = bus.md_result_i;
                end else if (timeout_hit) begin
                    state_d  = S_RESP;
                    result_d = '0;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            md_valid_q  <= 1'b0;
            inst_q      <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_valid_q  <= md_valid_d;
            inst_q      <= inst_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            result_q    <= result_d;
            rsp_valid_q <= (state_d == S_RESP);
        end
    end

`ifdef URISCV_MULDIV_ISSUE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             err_q;

    // Counter sits at zero while idle, so it starts from zero on every ISSUE entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                wd_cnt_q <= '0;
            end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
                wd_cnt_q <= wd_cnt_q + CNT_W'(1);
            end
            if (state_q != S_RESP && state_d == S_RESP) begin
                err_q <= !(state_q == S_WAIT && bus.md_ready_i);
            end
        end
    end

    assign timeout_hit   = (state_q == S_ISSUE || state_q == S_WAIT) &&
                           (wd_cnt_q == CNT_W'(TIMEOUT - 1));
    assign bus.rsp_err_o = err_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.rsp_err_o = 1'b0;
`endif

    // Ready is a decode of the idle state, masked so it reads low throughout reset
    assign bus.req_ready_o      = (state_q == S_IDLE) && !rst_i;
    assign bus.rsp_valid_o      = rsp_valid_q;
    assign bus.rsp_result_o     = result_q;
    assign bus.md_valid_o       = md_valid_q;
    assign bus.md_inst_mul_o    = inst_q[0];
    assign bus.md_inst_mulh_o   = inst_q[1];
    assign bus.md_inst_mulhsu_o = inst_q[2];
    assign bus.md_inst_mulhu_o  = inst_q[3];
    assign bus.md_inst_div_o    = inst_q[4];
    assign bus.md_inst_divu_o   = inst_q[5];
    assign bus.md_inst_rem_o    = inst_q[6];
    assign bus.md_inst_remu_o   = inst_q[7];
    assign bus.md_operand_ra_o  = ra_q;
    assign bus.md_operand_rb_o  = rb_q;
endmodule

// File: tb/tb_uriscv_muldiv_issue.sv
// Self-checking bench for uriscv_muldiv_issue with a behavioural mul/div unit attached.
module tb_uriscv_muldiv_issue;
    localparam int unsigned N       = 16;
    localparam int unsigned TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uriscv_muldiv_issue_if #(.N(N)) bus ();

    uriscv_muldiv_issue #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // RISC-V M-extension semantics at 16 bits, computed with wide integer arithmetic
    function automatic logic [15:0] ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {48'd0, a};
        ub = {48'd0, b};
        p  = 0;
        case (op)
            3'd0: begin p = ua * ub; return p[15:0];  end
            3'd1: begin p = sa * sb; return p[31:16]; end
            3'd2: begin p = sa * ub; return p[31:16]; end
            3'd3: begin p = ua * ub; return p[31:16]; end
            3'd4: begin
                if (b == 16'h0) return 16'hFFFF;
                if (a == 16'h8000 && b == 16'hFFFF) return a;
                p = sa / sb; return p[15:0];
            end
            3'd5: begin
                if (b == 16'h0) return 16'hFFFF;
                p = ua / ub; return p[15:0];
            end
            3'd6: begin
                if (b == 16'h0) return a;
                if (a == 16'h8000 && b == 16'hFFFF) return 16'h0;
                p = sa % sb; return p[15:0];
            end
            default: begin
                if (b == 16'h0) return a;
                p = ua % ub; return p[15:0];
            end
        endcase
    endfunction

    function automatic logic [2:0] op_of(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (oh[i]) r = 3'(i);
        return r;
    endfunction

    // Companion unit: stalls a programmable number of cycles, MUL ready 2 cycles and DIV 18 cycles after issue
    int          stall_req = 0;
    int          stall_seen = 0;
    logic        u_dead = 1'b0;
    logic        u_busy = 1'b0;
    int          u_rem = 0;
    logic [2:0]  u_op = 3'd0;
    logic [15:0] u_a = 16'h0;
    logic [15:0] u_b = 16'h0;
    logic [7:0]  md_inst;

    assign md_inst = {bus.md_inst_remu_o, bus.md_inst_rem_o, bus.md_inst_divu_o, bus.md_inst_div_o,
                      bus.md_inst_mulhu_o, bus.md_inst_mulhsu_o, bus.md_inst_mulh_o, bus.md_inst_mul_o};
    assign bus.md_stall_i  = bus.md_valid_o && (stall_seen < stall_req);
    assign bus.md_ready_i  = u_busy && (u_rem == 0) && !u_dead;
    assign bus.md_result_i = bus.md_ready_i ? ref_model(u_op, u_a, u_b) : 16'hA5A5;

    always @(posedge clk) begin
        stall_seen <= (bus.md_valid_o && bus.md_stall_i) ? stall_seen + 1 : 0;
        if (u_busy) begin
            if (u_rem == 0) u_busy <= 1'b0;
            else            u_rem  <= u_rem - 1;
        end
        if (bus.md_valid_o && !bus.md_stall_i) begin
            u_busy <= 1'b1;
            u_op   <= op_of(md_inst);
            u_a    <= bus.md_operand_ra_o;
            u_b    <= bus.md_operand_rb_o;
            u_rem  <= (op_of(md_inst) >= 3'd4) ? 17 : 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, output int t0);
        bit got;
        got = 0;
        t0  = 0;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_ra_i    = a;
        bus.req_rb_i    = b;
        for (int k = 0; k < 100 && !got; k++) begin
            if (bus.req_ready_o) begin
                got = 1;
                t0  = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    // Returns at the negedge of the first rsp_valid cycle; checks the md bus each cycle on the way
    task automatic wait_rsp(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int t0,
                            output int lat, output int n_issue, output int first, output logic md_ok);
        bit got;
        logic [7:0] exp_inst;
        got = 0;
        exp_inst = 8'b1 << op;
        lat = -1; n_issue = 0; first = -1; md_ok = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (bus.md_valid_o) begin
                n_issue++;
                if (first < 0) first = cyc - t0;
                if (md_inst !== exp_inst || bus.md_operand_ra_o !== a || bus.md_operand_rb_o !== b) md_ok = 1'b0;
            end else if (md_inst !== 8'h00 || bus.md_operand_ra_o !== 16'h0 || bus.md_operand_rb_o !== 16'h0) begin
                md_ok = 1'b0;
            end
            if (bus.req_ready_o) md_ok = 1'b0;
            if (bus.rsp_valid_o) begin
                got = 1;
                lat = cyc - t0;
            end
        end
    endtask

    task automatic take_rsp(input int hold, output logic [15:0] res, output logic err, output logic ok);
        res = bus.rsp_result_o;
        err = bus.rsp_err_o;
        ok  = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready_i = 1'b0;
            @(negedge clk);
            if (!bus.rsp_valid_o || bus.rsp_result_o !== res || bus.rsp_err_o !== err || bus.req_ready_o) ok = 1'b0;
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        if (bus.rsp_valid_o || !bus.req_ready_o) ok = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input int stall, input int hold, input logic [15:0] exp_res, input int exp_lat);
        int t0, lat, n_issue, first;
        logic md_ok, ok, err;
        logic [15:0] res;
        stall_req = stall;
        send_req(op, a, b, t0);
        wait_rsp(op, a, b, t0, lat, n_issue, first, md_ok);
        take_rsp(hold, res, err, ok);
        stall_req = 0;
        check($sformatf("%s_result", tag), 64'(res), 64'(exp_res));
        check($sformatf("%s_err", tag), 64'(err), 64'd0);
        check($sformatf("%s_latency", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("%s_issue_count", tag), 64'(n_issue), 64'(stall + 1));
        check($sformatf("%s_issue_cycle", tag), 64'(first), 64'd1);
        check($sformatf("%s_md_bus", tag), 64'(md_ok), 64'd1);
        check($sformatf("%s_rsp_hold", tag), 64'(ok), 64'd1);
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  stall;
        logic [7:0]  hold;
        logic [15:0] res;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1000000;
        $display("FAIL tb_global_timeout: simulation did not finish, got time %0t", $time);
        $fatal(1);
    end

    initial begin
        int t0, lat, n_issue, first;
        logic md_ok, ok, err, bad;
        logic [15:0] res;

        bus.req_valid_i = 1'b0;
        bus.req_op_i    = 3'd0;
        bus.req_ra_i    = 16'h0;
        bus.req_rb_i    = 16'h0;
        bus.rsp_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {4'h0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.md_valid_o, md_inst,
               bus.md_operand_ra_o, bus.md_operand_rb_o, bus.rsp_result_o}, 64'd0);
        rst = 1'b0;
        #1 check("reset_release_ready", 64'(bus.req_ready_o), 64'd1);

        //           op    a         b         stall hold  result    lat
        vecs[0]  = '{3'd0, 16'h0003, 16'h0005, 8'd0, 8'd0, 16'h000F, 8'd4};
        vecs[1]  = '{3'd1, 16'hFFFF, 16'h0002, 8'd0, 8'd0, 16'hFFFF, 8'd4};
        vecs[2]  = '{3'd3, 16'hFFFF, 16'hFFFF, 8'd0, 8'd0, 16'hFFFE, 8'd4};
        vecs[3]  = '{3'd2, 16'hFFFF, 16'hFFFF, 8'd0, 8'd1, 16'hFFFF, 8'd4};
        vecs[4]  = '{3'd4, 16'hFFF9, 16'h0002, 8'd0, 8'd0, 16'hFFFD, 8'd20};
        vecs[5]  = '{3'd6, 16'hFFF9, 16'h0002, 8'd0, 8'd0, 16'hFFFF, 8'd20};
        vecs[6]  = '{3'd5, 16'h0064, 16'h0000, 8'd0, 8'd0, 16'hFFFF, 8'd20};
        vecs[7]  = '{3'd0, 16'h1234, 16'h0010, 8'd3, 8'd5, 16'h2340, 8'd7};
        vecs[8]  = '{3'd4, 16'h8000, 16'hFFFF, 8'd1, 8'd1, 16'h8000, 8'd21};
        vecs[9]  = '{3'd6, 16'h8000, 16'hFFFF, 8'd0, 8'd0, 16'h0000, 8'd20};
        vecs[10] = '{3'd7, 16'h0064, 16'h0000, 8'd0, 8'd2, 16'h0064, 8'd20};

        for (int i = 0; i < 11; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, int'(vecs[i].stall),
                    int'(vecs[i].hold), vecs[i].res, int'(vecs[i].lat));
        end

        // Reset while a DIV waits in the unit: everything drops at once and no response follows
        send_req(3'd4, 16'hFFF9, 16'h0002, t0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("midop_reset_outputs",
                 {4'h0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.md_valid_o, md_inst,
                  bus.md_operand_ra_o, bus.md_operand_rb_o, bus.rsp_result_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midop_release_ready", 64'(bus.req_ready_o), 64'd1);
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid_o || bus.md_valid_o || !bus.req_ready_o) bad = 1'b1;
        end
        check("midop_no_response", 64'(bad), 64'd0);

        // Request raised in the response handshake cycle is taken only in the next IDLE cycle
        send_req(3'd0, 16'h0007, 16'h0009, t0);
        wait_rsp(3'd0, 16'h0007, 16'h0009, t0, lat, n_issue, first, md_ok);
        check("b2b_first_result", 64'(bus.rsp_result_o), 64'h003F);
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 3'd3;
        bus.req_ra_i    = 16'hFFFF;
        bus.req_rb_i    = 16'hFFFF;
        check("b2b_not_ready_in_handshake", 64'(bus.req_ready_o), 64'd0);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("b2b_idle_cycle", {61'd0, bus.req_ready_o, bus.md_valid_o, bus.rsp_valid_o}, 64'b100);
        t0 = cyc;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        wait_rsp(3'd3, 16'hFFFF, 16'hFFFF, t0, lat, n_issue, first, md_ok);
        take_rsp(0, res, err, ok);
        check("b2b_second_latency", 64'(lat), 64'd4);
        check("b2b_second_issue", {62'd0, md_ok, first == 1 && n_issue == 1}, 64'b11);
        check("b2b_second_result", 64'(res), 64'hFFFE);

`ifdef URISCV_MULDIV_ISSUE_TIMEOUT_EN
        // Unit never answers: watchdog responds with an error TIMEOUT cycles after ISSUE entry
        u_dead = 1'b1;
        send_req(3'd0, 16'h0002, 16'h0003, t0);
        wait_rsp(3'd0, 16'h0002, 16'h0003, t0, lat, n_issue, first, md_ok);
        take_rsp(0, res, err, ok);
        u_dead = 1'b0;
        check("wd_latency", 64'(lat), 64'(TIMEOUT + 1));
        check("wd_result", 64'(res), 64'd0);
        check("wd_err", 64'(err), 64'd1);
        check("wd_rsp_hold", 64'(ok), 64'd1);
`endif

        // Randomized operations checked against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [15:0] a, b;
            int stall, hold;
            op    = 3'($urandom_range(0, 7));
            a     = 16'($urandom);
            b     = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a = 16'h8000;
                b = 16'hFFFF;
            end
            stall = int'($urandom_range(0, 2));
            hold  = int'($urandom_range(0, 2));
            run_one($sformatf("rnd%0d", i), op, a, b, stall, hold, ref_model(op, a, b),
                    ((op < 3'd4) ? 4 : 20) + stall);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
